shifter_seq_32: RTL and testbench

SHIFTER_SEQ_32 -- requirements
Module: shifter_seq_32

---
 rtl/shifter_pkg.sv | 9 +
 rtl/shift_step_32.sv | 14 +
 rtl/shifter_seq_32.sv | 56 +++++
 tb/tb_shifter_seq_32.sv | 121 ++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// shifter_pkg: shared encodings for the sequential 32-bit shifter
package shifter_pkg;
    localparam int CNT_W = 5;
    localparam logic [1:0] SEL_SLL = 2'b00;
    localparam logic [1:0] SEL_SRL = 2'b01;
    localparam logic [1:0] SEL_SRA = 2'b10;
    localparam logic [1:0] SEL_ROR = 2'b11;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/shift_step_32.sv
// shift_step_32: one-bit-position shift or rotate of a 32-bit value
module shift_step_32
    import shifter_pkg::*;
(
    input  logic [31:0] value,
    input  logic [1:0]  op,
    output logic [31:0] shifted
);
    always_comb
        shifted = op == SEL_SLL ? {value[30:0], 1'b0} :
                  op == SEL_SRL ? {1'b0, value[31:1]} :
                  op == SEL_SRA ? {value[31], value[31:1]} :
                                  {value[0], value[31:1]};
endmodule

// File: rtl/shifter_seq_32.sv
// shifter_seq_32: multi-cycle 32-bit shifter, one bit position per clock
module shifter_seq_32
    import shifter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  select,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);
    state_e state, state_nxt;
    logic [31:0] work, stepped;
    logic [CNT_W-1:0] cnt;
    logic [1:0] op;
    logic load;
    logic unused_b;

    assign unused_b = ^b[31:CNT_W];
    assign load = start && state != SHIFT;
    assign busy = state == SHIFT;
    assign done = state == DONE;

    shift_step_32 u_step (.value(work), .op(op), .shifted(stepped));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = IDLE;
        if (load) state_nxt = b[CNT_W-1:0] != '0 ? SHIFT : DONE;
        else if (state == SHIFT) state_nxt = cnt == CNT_W'(1) ? DONE : SHIFT;
    end

    // out is written only on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            work <= '0;
            cnt  <= '0;
            op   <= SEL_SLL;
            out  <= '0;
        end else if (load) begin
            work <= a;
            cnt  <= b[CNT_W-1:0];
            op   <= select;
            if (b[CNT_W-1:0] == '0) out <= a;
        end else if (busy) begin
            work <= stepped;
            cnt  <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) out <= stepped;
        end
endmodule

// File: tb/tb_shifter_seq_32.sv
// tb_shifter_seq_32: directed vectors with a scoreboard checking result and done latency
module tb_shifter_seq_32;
    logic        clk = 0, rst_n = 0, start = 0;
    logic [31:0] a = 0, b = 0;
    logic [1:0]  select = 0;
    logic        busy, done;
    logic [31:0] out;
    int cyc = 0, compared = 0, mismatched = 0;

    typedef struct {logic [31:0] val; int cyc;} exp_t;
    exp_t q[$];
    exp_t e;

    shifter_seq_32 dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
                        .select(select), .busy(busy), .done(done), .out(out));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // done at negedge of cycle s+N where s is the cycle count just after the start edge
    always @(negedge clk)
        if (rst_n && done) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: out %h with empty scoreboard", out);
            end else begin
                e = q.pop_front();
                check("out", out, e.val);
                check("done_latency", 32'(cyc), 32'(e.cyc));
            end
        end

    task automatic go(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] ts,
                      input logic [31:0] want);
        start = 1; a = ta; b = tb; select = ts;
        @(posedge clk); #1;
        q.push_back('{want, cyc + int'(tb[4:0])});
        start = 0;
    endtask

    task automatic run(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] ts,
                       input logic [31:0] want, input bit b2b, input bit tog);
        int n = 0;
        go(ta, tb, ts, want);
        while (busy && n < 100) begin
            if (tog) begin
                start = n < 10 ? ~start : 1'b0;
                a = a + 32'h1111_1111;
                b = b ^ 32'h7;
                select = select + 2'd1;
            end
            n++;
            @(posedge clk); #1;
        end
        check("busy_cycles", 32'(n), 32'(tb[4:0]));
        check("done_pulse", {31'b0, done}, 32'h1);
        if (!b2b) begin
            @(posedge clk); #1;
            check("idle_after_done", {30'b0, busy, done}, 32'h0);
            check("out_hold", out, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        #12;
        check("reset_out", out, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        run(32'h0000_0001, 32'd4,  2'b00, 32'h0000_0010, 0, 0);
        run(32'h8000_0000, 32'd31, 2'b10, 32'hFFFF_FFFF, 0, 0);
        run(32'h8000_0000, 32'd31, 2'b01, 32'h0000_0001, 0, 0);
        run(32'hDEAD_BEEF, 32'h20, 2'b01, 32'hDEAD_BEEF, 0, 0);
        run(32'h0000_00F1, 32'd4,  2'b11, 32'h1000_000F, 1, 0);
        run(32'h0000_0001, 32'd1,  2'b00, 32'h0000_0002, 0, 0);
        run(32'hFFFF_FFFF, 32'd20, 2'b00, 32'hFFF0_0000, 0, 1);
        run(32'h7000_0000, 32'd4,  2'b10, 32'h0700_0000, 0, 0);
        run(32'hF000_0000, 32'd28, 2'b01, 32'h0000_000F, 0, 0);
        run(32'h1234_5678, 32'd8,  2'b11, 32'h7812_3456, 0, 0);
        run(32'h8000_0001, 32'd31, 2'b11, 32'h0000_0003, 0, 0);
        run(32'h0000_0001, 32'd31, 2'b00, 32'h8000_0000, 0, 0);
        run(32'h0000_0001, 32'hFFFF_FFE3, 2'b00, 32'h0000_0008, 0, 0);
        // abort mid-operation: nothing is pushed, so any later done is flagged
        start = 1; a = 32'h1234_5678; b = 32'd20; select = 2'b00;
        @(posedge clk); #1;
        start = 0;
        repeat (9) @(posedge clk);
        #2;
        check("busy_before_abort", {31'b0, busy}, 32'h1);
        rst_n = 0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_out", out, 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (40) @(posedge clk);
        #1;
        check("abort_out_stays", out, 32'h0);
        run(32'h0000_0003, 32'd2, 2'b00, 32'h0000_000C, 0, 0);
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
